// File: rtl/sram_arb_ctrl_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM encodings, byte-lane
// indices within a halfword, bus widths and the half-skip helper.
package sram_arb_ctrl_pkg;

   localparam int SRAM_DW = 16;   // SRAM data bus width
   localparam int LANE_LB = 0;    // lower byte lane of a halfword
   localparam int LANE_UB = 1;    // upper byte lane of a halfword

   // Word-level arbiter sequencing
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } arb_state_e;

   // Phases of one halfword SRAM access
   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } half_phase_e;

   // Access attributes latched when leaving IDLE
   typedef struct packed {
      logic        mem;    // 1 = MEM port granted, 0 = IF port
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } xfer_t;

   // A half is performed for every read, and for writes with any lane enabled
   function automatic logic half_en(input logic we, input logic [1:0] sel);
      return ~we | (|sel);
   endfunction

endpackage

// File: rtl/sram_arb_ctrl_half_cycle.sv
// One halfword SRAM access: SETUP, STROBE for WAIT_CYCLES cycles, then HOLD.
// done_o is high during HOLD; a start_i seen in HOLD chains straight into the
// next SETUP so the two halves of a word run back to back.
module sram_arb_ctrl_half_cycle
   import sram_arb_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               we_i,
   input  logic [1:0]         sel_i,
   input  logic [SRAM_DW-1:0] wdata_i,
   input  logic [SRAM_DW-1:0] dq_i,
   output logic               ce_n_o,
   output logic               oe_n_o,
   output logic               we_n_o,
   output logic               lb_n_o,
   output logic               ub_n_o,
   output logic               dq_oe_o,
   output logic [SRAM_DW-1:0] dq_o,
   output logic               done_o,
   output logic [SRAM_DW-1:0] rdata_o
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

   half_phase_e        ph_q, ph_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [SRAM_DW-1:0] rdata_q, rdata_d;
   logic               active;

   // Phase sequencing; read data is captured on the last strobe cycle
   always_comb begin
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (ph_q)
         PH_IDLE:   if (start_i) ph_d = PH_SETUP;
         PH_SETUP: begin
            ph_d  = PH_STROBE;
            cnt_d = '0;
         end
         PH_STROBE: begin
            if (cnt_q == CNT_LAST) begin
               ph_d = PH_HOLD;
               if (!we_i) rdata_d = dq_i;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PH_HOLD:   ph_d = start_i ? PH_SETUP : PH_IDLE;
         default:   ph_d = PH_IDLE;
      endcase
   end

   // Phase, wait counter and captured halfword
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph_q    <= PH_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from the phase register so reset forces them high
   assign active  = (ph_q != PH_IDLE);
   assign ce_n_o  = ~active;
   assign oe_n_o  = ~((ph_q == PH_STROBE) & ~we_i);
   assign we_n_o  = ~((ph_q == PH_STROBE) & we_i);
   assign lb_n_o  = ~(active & (~we_i | sel_i[LANE_LB]));
   assign ub_n_o  = ~(active & (~we_i | sel_i[LANE_UB]));
   assign dq_oe_o = active & we_i;
   assign dq_o    = dq_oe_o ? wdata_i : '0;
   assign done_o  = (ph_q == PH_HOLD);
   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbitrates the 16-bit SRAM between the fetch and MEM ports. MEM wins in
// IDLE; each word is done as a low then a high halfword access, with
// write halves skipped when both of their byte enables are clear.
module sram_arb_ctrl
   import sram_arb_ctrl_pkg::*;
#(
   parameter int SRAM_AW     = 19,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [31:0]        if_addr,
   output logic [31:0]        if_rdata,
   output logic               if_ack,
   input  logic               mem_req,
   input  logic               mem_we,
   input  logic [3:0]         mem_sel,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_wdata,
   output logic [31:0]        mem_rdata,
   output logic               mem_ack,
   output logic               stallreq,
   output logic [SRAM_AW-1:0] sram_addr,
   input  logic [SRAM_DW-1:0] sram_dq_i,
   output logic [SRAM_DW-1:0] sram_dq_o,
   output logic               sram_dq_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   arb_state_e         state_q, state_d;
   xfer_t              xfer_q, xfer_d;
   logic [SRAM_AW-2:0] waddr_q, waddr_d;
   logic [SRAM_DW-1:0] rd_lo_q, rd_lo_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic [31:0]        mem_rdata_q, mem_rdata_d;

   logic               hc_start, hc_done, half_hi;
   logic [1:0]         hc_sel;
   logic [SRAM_DW-1:0] hc_wdata, hc_rdata;
   logic               unused_addr_bits;

   // Arbitration, half ordering with write-lane skip, and read data assembly
   always_comb begin
      state_d     = state_q;
      xfer_d      = xfer_q;
      waddr_d     = waddr_q;
      rd_lo_d     = rd_lo_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      hc_start    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_req | if_req) begin
               xfer_d.mem   = mem_req;
               xfer_d.we    = mem_req & mem_we;
               xfer_d.sel   = mem_req ? mem_sel : 4'hF;
               xfer_d.wdata = mem_req ? mem_wdata : '0;
               waddr_d      = mem_req ? mem_addr[SRAM_AW:2] : if_addr[SRAM_AW:2];
               if (half_en(xfer_d.we, xfer_d.sel[1:0])) begin
                  state_d  = ST_LOW;
                  hc_start = 1'b1;
               end else if (half_en(xfer_d.we, xfer_d.sel[3:2])) begin
                  state_d  = ST_HIGH;
                  hc_start = 1'b1;
               end else begin
                  state_d  = ST_DONE;
               end
            end
         end
         ST_LOW: begin
            if (hc_done) begin
               rd_lo_d = hc_rdata;
               if (half_en(xfer_q.we, xfer_q.sel[3:2])) begin
                  state_d  = ST_HIGH;
                  hc_start = 1'b1;
               end else begin
                  state_d  = ST_DONE;
               end
            end
         end
         ST_HIGH: begin
            if (hc_done) begin
               state_d = ST_DONE;
               if (!xfer_q.we) begin
                  if (xfer_q.mem) mem_rdata_d = {hc_rdata, rd_lo_q};
                  else            if_rdata_d  = {hc_rdata, rd_lo_q};
               end
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Arbiter state, latched access and returned read words
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         xfer_q      <= '0;
         waddr_q     <= '0;
         rd_lo_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         xfer_q      <= xfer_d;
         waddr_q     <= waddr_d;
         rd_lo_q     <= rd_lo_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign half_hi  = (state_q == ST_HIGH);
   assign hc_sel   = half_hi ? xfer_q.sel[3:2] : xfer_q.sel[1:0];
   assign hc_wdata = half_hi ? xfer_q.wdata[31:16] : xfer_q.wdata[15:0];

   sram_arb_ctrl_half_cycle #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_half (
      .clk     (clk),
      .rst     (rst),
      .start_i (hc_start),
      .we_i    (xfer_q.we),
      .sel_i   (hc_sel),
      .wdata_i (hc_wdata),
      .dq_i    (sram_dq_i),
      .ce_n_o  (sram_ce_n),
      .oe_n_o  (sram_oe_n),
      .we_n_o  (sram_we_n),
      .lb_n_o  (sram_lb_n),
      .ub_n_o  (sram_ub_n),
      .dq_oe_o (sram_dq_oe),
      .dq_o    (sram_dq_o),
      .done_o  (hc_done),
      .rdata_o (hc_rdata)
   );

   assign sram_addr = {waddr_q, half_hi};
   assign if_ack    = (state_q == ST_DONE) & ~xfer_q.mem;
   assign mem_ack   = (state_q == ST_DONE) & xfer_q.mem;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign stallreq  = rst & (if_req | mem_req) & ~(if_ack | mem_ack);

   // Byte-offset and above-SRAM address bits carry no information here
   assign unused_addr_bits = ^{if_addr[31:SRAM_AW+1], if_addr[1:0],
                               mem_addr[31:SRAM_AW+1], mem_addr[1:0]};

endmodule
